// File: rtl/pipe_ctrl_pkg.sv
// Shared types and PIPE encodings for the MAC-side PIPE control sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {DETECT = 2'd0, POWERDOWN = 2'd1, RATE = 2'd2} ctrl_op_e;
    typedef enum logic [1:0] {OK = 2'd0, TIMEOUT = 2'd1, ILLEGAL = 2'd2} ctrl_status_e;

    typedef enum logic [2:0] {
        ST_RST_HOLD, ST_WAIT_READY, ST_IDLE, ST_DETECT, ST_PD_WAIT, ST_RATE_WAIT, ST_RESP
    } ctrl_state_e;

    localparam logic [3:0] PD_P0  = 4'h0;
    localparam logic [3:0] PD_P0S = 4'h1;
    localparam logic [3:0] PD_P1  = 4'h2;
    localparam logic [3:0] PD_P2  = 4'h3;

    localparam logic [2:0] RX_DETECTED = 3'b011;

endpackage

// File: rtl/pipe_wait_timer.sv
// Saturating cycle counter with synchronous clear; tc is high once the count reaches limit.
module pipe_wait_timer #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    output logic          tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + CW'(1);
    end

    assign tc = (cnt >= limit);

endmodule

// File: rtl/pipe_phy_ctrl_seq.sv
// MAC-side PIPE control sequencer for one lane: PHY reset bring-up, then
// single DETECT / POWERDOWN / RATE commands completed on PhyStatus or timeout.
module pipe_phy_ctrl_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int         RESET_HOLD  = 16,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [3:0] P1_CODE     = PD_P1,
    parameter logic [3:0] P0_CODE     = PD_P0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [3:0] req_arg,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic       rsp_rx_present,
    output logic       phy_ready,
    input  logic       PhyStatus,
    input  logic [2:0] RxStatus,
    output logic       phy_reset_n,
    output logic [3:0] Powerdown,
    output logic [3:0] Rate,
    output logic       TxDetectRx,
    output logic       TxElecIdle
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    ctrl_state_e  state, state_n;
    ctrl_status_e stat_q, stat_n;
    logic [3:0]   pd_q, pd_n, rate_q, rate_n;
    logic         det_q, det_n, prst_q, prst_n, rxp_q, rxp_n, rdy_q, rdy_n;
    logic         tc, clr;
    logic [CW-1:0] limit;

    // One timer serves the reset hold and every PhyStatus wait; it restarts on each state change.
    assign clr   = (state_n != state);
    assign limit = (state == ST_RST_HOLD) ? CW'(RESET_HOLD - 1) : CW'(TIMEOUT_CYC);

    pipe_wait_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .limit (limit),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RST_HOLD;
            stat_q <= OK;
            pd_q   <= P1_CODE;
            rate_q <= 4'h0;
            det_q  <= 1'b0;
            prst_q <= 1'b0;
            rxp_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_n;
            stat_q <= stat_n;
            pd_q   <= pd_n;
            rate_q <= rate_n;
            det_q  <= det_n;
            prst_q <= prst_n;
            rxp_q  <= rxp_n;
            rdy_q  <= rdy_n;
        end
    end

    always_comb begin
        state_n = state;
        stat_n  = stat_q;
        pd_n    = pd_q;
        rate_n  = rate_q;
        det_n   = det_q;
        prst_n  = prst_q;
        rxp_n   = rxp_q;
        rdy_n   = rdy_q;
        case (state)
            ST_RST_HOLD: if (tc) begin
                prst_n  = 1'b1;
                state_n = ST_WAIT_READY;
            end
            // A PHY that never drops PhyStatus leaves phy_ready low; commands then all fail ILLEGAL.
            ST_WAIT_READY: if (!PhyStatus) begin
                rdy_n   = 1'b1;
                state_n = ST_IDLE;
            end else if (tc) begin
                state_n = ST_IDLE;
            end
            ST_IDLE: if (req_valid) begin
                rxp_n   = 1'b0;
                stat_n  = ILLEGAL;
                state_n = ST_RESP;
                if (rdy_q) begin
                    case (req_op)
                        DETECT: if (pd_q == P1_CODE) begin
                            det_n   = 1'b1;
                            stat_n  = OK;
                            state_n = ST_DETECT;
                        end
                        POWERDOWN: begin
                            pd_n    = req_arg;
                            stat_n  = OK;
                            state_n = ST_PD_WAIT;
                        end
                        RATE: if (pd_q == P0_CODE) begin
                            rate_n  = req_arg;
                            stat_n  = OK;
                            state_n = ST_RATE_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            // Completion is tested before timeout so a same-cycle PhyStatus reports OK.
            ST_DETECT, ST_PD_WAIT, ST_RATE_WAIT: if (PhyStatus) begin
                if (state == ST_DETECT) rxp_n = (RxStatus == RX_DETECTED);
                det_n   = 1'b0;
                state_n = ST_RESP;
            end else if (tc) begin
                det_n   = 1'b0;
                stat_n  = TIMEOUT;
                state_n = ST_RESP;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_RST_HOLD;
        endcase
    end

    assign req_ready      = (state == ST_IDLE);
    assign rsp_valid      = (state == ST_RESP);
    assign rsp_status     = stat_q;
    assign rsp_rx_present = rxp_q;
    assign phy_ready      = rdy_q;
    assign phy_reset_n    = prst_q;
    assign Powerdown      = pd_q;
    assign Rate           = rate_q;
    assign TxDetectRx     = det_q;
    assign TxElecIdle     = (pd_q != P0_CODE);

endmodule

// File: tb/tb_pipe_phy_ctrl_seq.sv
// Directed bench for pipe_phy_ctrl_seq with hand-computed cycle timing.
module tb_pipe_phy_ctrl_seq;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_op;
    logic [3:0] req_arg;
    logic       req_ready, rsp_valid, rsp_rx_present, phy_ready;
    logic [1:0] rsp_status;
    logic       PhyStatus;
    logic [2:0] RxStatus;
    logic       phy_reset_n, TxDetectRx, TxElecIdle;
    logic [3:0] Powerdown, Rate;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_phy_ctrl_seq dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_arg        (req_arg),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_status     (rsp_status),
        .rsp_rx_present (rsp_rx_present),
        .phy_ready      (phy_ready),
        .PhyStatus      (PhyStatus),
        .RxStatus       (RxStatus),
        .phy_reset_n    (phy_reset_n),
        .Powerdown      (Powerdown),
        .Rate           (Rate),
        .TxDetectRx     (TxDetectRx),
        .TxElecIdle     (TxElecIdle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command in IDLE; returns one cycle after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] arg);
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        tick();
        req_valid = 1'b0;
    endtask

    // PhyStatus pulse on the dly-th cycle after acceptance.
    task automatic ack(input int dly, input logic [2:0] rxs);
        repeat (dly - 1) tick();
        PhyStatus = 1'b1;
        RxStatus  = rxs;
        tick();
        PhyStatus = 1'b0;
        RxStatus  = 3'b000;
    endtask

    task automatic rsp(input string tag, input logic [1:0] st, input logic rx);
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_st"}, rsp_status, st);
        chk({tag, "_rx"}, rsp_rx_present, rx);
        tick();
        chk({tag, "_pulse"}, rsp_valid, 0);
        chk({tag, "_idle"}, req_ready, 1);
    endtask

    initial begin
        int k;
        int seen;
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_arg = 4'h0;
        PhyStatus = 1'b1; RxStatus = 3'b000;
        repeat (3) tick();
        chk("rst_prst", phy_reset_n, 0);
        chk("rst_pd", Powerdown, 4'h2);
        chk("rst_rate", Rate, 0);
        chk("rst_eidle", TxElecIdle, 1);
        chk("rst_det", TxDetectRx, 0);
        chk("rst_rdy", {req_ready, rsp_valid, phy_ready}, 0);

        // Power-on: Reset# held 16 edges, PhyStatus busy for 40 cycles.
        reset = 1'b0;
        repeat (15) tick();
        chk("prst_15", phy_reset_n, 0);
        tick();
        chk("prst_16", phy_reset_n, 1);
        repeat (24) tick();
        chk("rdy_busy", phy_ready, 0);
        PhyStatus = 1'b0;
        tick();
        chk("rdy_up", phy_ready, 1);
        chk("rdy_req", req_ready, 1);
        chk("rdy_pd", Powerdown, 4'h2);
        chk("rdy_eidle", TxElecIdle, 1);

        // DETECT in P1, receiver present
        send(DETECT, 4'h0);
        chk("det1_tx", TxDetectRx, 1);
        chk("det1_busy", req_ready, 0);
        repeat (9) tick();
        chk("det1_tx10", TxDetectRx, 1);
        PhyStatus = 1'b1; RxStatus = 3'b011;
        tick();
        PhyStatus = 1'b0; RxStatus = 3'b000;
        chk("det1_txoff", TxDetectRx, 0);
        rsp("det1", 2'd0, 1'b1);

        // DETECT, nothing present
        send(DETECT, 4'h0);
        ack(3, 3'b000);
        rsp("det0", 2'd0, 1'b0);

        // PhyStatus in IDLE is ignored
        PhyStatus = 1'b1;
        tick();
        PhyStatus = 1'b0;
        tick();
        chk("idle_ps_rdy", req_ready, 1);
        chk("idle_ps_vld", rsp_valid, 0);

        // Illegal: RATE in P1, reserved op
        send(RATE, 4'h1);
        rsp("rate_p1", 2'd2, 1'b0);
        chk("rate_p1_rate", Rate, 0);
        send(2'd3, 4'h0);
        rsp("op3", 2'd2, 1'b0);
        chk("op3_pd", Powerdown, 4'h2);

        // P1 -> P0, then rate change
        send(POWERDOWN, 4'h0);
        chk("pd0_pd", Powerdown, 4'h0);
        chk("pd0_eidle", TxElecIdle, 0);
        ack(2, 3'b000);
        rsp("pd0", 2'd0, 1'b0);
        send(RATE, 4'h1);
        chk("rate1_rate", Rate, 4'h1);
        ack(2, 3'b000);
        rsp("rate1", 2'd0, 1'b0);

        // DETECT in P0 is illegal
        send(DETECT, 4'h0);
        chk("det_p0_tx", TxDetectRx, 0);
        rsp("det_p0", 2'd2, 1'b0);

        // POWERDOWN 3 without PhyStatus: timeout after 1024 cycles in PD_WAIT + 1
        send(POWERDOWN, 4'h3);
        k = 0;
        while (!rsp_valid && k < 1100) begin
            tick();
            k++;
        end
        chk("pd3_to_lat", k, 1025);
        rsp("pd3", 2'd1, 1'b0);
        chk("pd3_pd", Powerdown, 4'h3);
        chk("pd3_eidle", TxElecIdle, 1);

        // PhyStatus on the terminal-count cycle wins
        send(POWERDOWN, 4'h2);
        ack(1025, 3'b000);
        rsp("pd2_tc", 2'd0, 1'b0);
        chk("pd2_pd", Powerdown, 4'h2);

        // Reset mid-DETECT
        send(DETECT, 4'h0);
        repeat (3) tick();
        chk("mid_det_tx", TxDetectRx, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", TxDetectRx, 0);
        chk("mid_rst_prst", phy_reset_n, 0);
        chk("mid_rst_rdy", phy_ready, 0);
        PhyStatus = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // PHY never leaves busy: WAIT_READY timeout, phy_ready stays low
        k = 0;
        seen = 0;
        while (!req_ready && k < 1200) begin
            tick();
            k++;
            if (rsp_valid) seen++;
        end
        chk("wr_to_lat", k, 1041);
        chk("wr_no_rsp", seen, 0);
        chk("wr_rdy", phy_ready, 0);
        PhyStatus = 1'b0;
        send(POWERDOWN, 4'h0);
        rsp("nordy", 2'd2, 1'b0);
        chk("nordy_pd", Powerdown, 4'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
